// File: rtl/proc_pkg.sv
// Shared definitions for the instruction sequencer and the datapath control
// unit: instruction layout, opcode values and the sequencer state encoding.
package proc_pkg;

    localparam int INSTR_W = 13;

    // Instruction field positions: [12:9] opcode, [8:6] rs, [5:3] rt, [2:0] rd
    localparam int OPC_MSB = 12;
    localparam int OPC_LSB = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int RT_MSB  = 5;
    localparam int RT_LSB  = 3;
    localparam int RD_MSB  = 2;
    localparam int RD_LSB  = 0;

    // Opcodes understood by the control unit; OP_HALT stops the sequencer
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] HALT_OPCODE_DEF = OP_HALT;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DECODE,
        ST_EXEC,
        ST_HALT
    } state_e;

endpackage

// File: rtl/proc_sequencer_if.sv
// Instruction-memory and datapath connections of the sequencer. The
// sequencer is the master; memory plus datapath form the slave side.
interface proc_sequencer_if #(
    parameter int PC_W = 8
);
    import proc_pkg::*;

    logic                 imem_rd;
    logic [PC_W-1:0]      imem_addr;
    logic [INSTR_W-1:0]   imem_data;
    logic [3:0]           opcode_o;
    logic [2:0]           rs_o;
    logic [2:0]           rt_o;
    logic [2:0]           rd_o;
    logic                 exec_en;
    logic [7:0]           alu_result;

    modport master (
        output imem_rd, imem_addr, opcode_o, rs_o, rt_o, rd_o, exec_en,
        input  imem_data, alu_result
    );

    modport slave (
        input  imem_rd, imem_addr, opcode_o, rs_o, rt_o, rd_o, exec_en,
        output imem_data, alu_result
    );

endinterface

// File: rtl/proc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> WAIT -> DECODE -> EXEC (CPI 4).
// Holds the PC, the instruction register, the last ALU result and a
// saturating retired-instruction counter. A stop request is deferred to the
// next instruction boundary; a HALT opcode parks the sequencer until start.
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int         PC_W        = 8,
    parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEF,
    parameter int         CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    proc_sequencer_if.master     bus,
    output logic [7:0]           result_q,
    output logic                 result_valid,
    output logic [PC_W-1:0]      pc,
    output logic [CNT_W-1:0]     retired,
    output logic                 busy,
    output logic                 halted
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [7:0]           result_d;
    logic                 result_valid_q, result_valid_d;
    logic                 stop_pending_q, stop_pending_d;
    logic                 imem_rd;
    logic                 exec_en;

    // State and datapath registers; everything returns to zero / IDLE on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pc_q           <= '0;
            retired_q      <= '0;
            ir_q           <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            stop_pending_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q        <= state_d;
            pc_q           <= pc_d;
            retired_q      <= retired_d;
            ir_q           <= ir_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    // Next-state and strobe logic for the fetch/decode/execute sequence
    always_comb begin
        // NOTE: every variable gets its hold/idle value first so no path
        // through the case statement leaves one unassigned (no latches).
        state_d        = state_q;
        pc_d           = pc_q;
        retired_d      = retired_q;
        ir_d           = ir_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        stop_pending_d = stop_pending_q;
        imem_rd        = 1'b0;
        exec_en        = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                // stop is meaningless here; start always restarts from PC 0
                if (start) begin
                    state_d        = ST_FETCH;
                    pc_d           = '0;
                    retired_d      = '0;
                    stop_pending_d = 1'b0;
                end
            end
            ST_FETCH: begin
                imem_rd = 1'b1;
                if (stop) stop_pending_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                ir_d = bus.imem_data;
                if (stop) stop_pending_d = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (ir_q[OPC_MSB:OPC_LSB] == HALT_OPCODE) begin
                    // HALT takes precedence over any outstanding stop request
                    state_d        = ST_HALT;
                    stop_pending_d = 1'b0;
                end else begin
                    if (stop) stop_pending_d = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                exec_en        = 1'b1;
                result_d       = bus.alu_result;
                result_valid_d = 1'b1;
                pc_d           = pc_q + PC_W'(1);
                retired_d      = (&retired_q) ? retired_q : retired_q + CNT_W'(1);
                if (stop_pending_q || stop) begin
                    state_d        = ST_IDLE;
                    stop_pending_d = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Field outputs follow the instruction register in every state;
    // exec_en is the only qualifier the datapath should trust.
    assign bus.imem_rd   = imem_rd;
    assign bus.imem_addr = pc_q;
    assign bus.exec_en   = exec_en;
    assign bus.opcode_o  = ir_q[OPC_MSB:OPC_LSB];
    assign bus.rs_o      = ir_q[RS_MSB:RS_LSB];
    assign bus.rt_o      = ir_q[RT_MSB:RT_LSB];
    assign bus.rd_o      = ir_q[RD_MSB:RD_LSB];

    assign result_valid = result_valid_q;
    assign pc           = pc_q;
    assign retired      = retired_q;
    assign busy         = (state_q == ST_FETCH) || (state_q == ST_WAIT) ||
                          (state_q == ST_DECODE) || (state_q == ST_EXEC);
    assign halted       = (state_q == ST_HALT);

endmodule
